// File: rtl/float_max_reduce_pkg.sv
// Shared float32 helpers: canonical NaN, field slices, classification functions
// and the reduction FSM state type.
package float_max_reduce_pkg;

    localparam logic [31:0] FLOAT_NAN_CANON = 32'h7FC0_0000;

    localparam int unsigned FLOAT_SIGN_BIT = 31;
    localparam int unsigned FLOAT_EXP_MSB  = 30;
    localparam int unsigned FLOAT_EXP_LSB  = 23;
    localparam int unsigned FLOAT_MAN_MSB  = 22;
    localparam int unsigned FLOAT_MAN_LSB  = 0;

    function automatic logic float_is_nan(input logic [31:0] x);
        return (&x[FLOAT_EXP_MSB:FLOAT_EXP_LSB]) && (|x[FLOAT_MAN_MSB:FLOAT_MAN_LSB]);
    endfunction

    function automatic logic float_is_zero(input logic [31:0] x);
        return x[FLOAT_EXP_MSB:0] == '0;
    endfunction

    typedef enum logic [1:0] {
        ST_FIRST,
        ST_ACCUM,
        ST_DONE
    } reduce_state_t;

endpackage

// File: rtl/float_gt.sv
// Combinational float32 strict greater-than: sign-magnitude ordering,
// +0 == -0, and any NaN operand yields 0.
module float_gt
    import float_max_reduce_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        gt
);

    always_comb begin
        gt = 1'b0;
        if (float_is_nan(a) || float_is_nan(b) || (float_is_zero(a) && float_is_zero(b))) begin
            gt = 1'b0;
        end else if (a[FLOAT_SIGN_BIT] != b[FLOAT_SIGN_BIT]) begin
            gt = !a[FLOAT_SIGN_BIT];
        end else if (!a[FLOAT_SIGN_BIT]) begin
            gt = a[FLOAT_EXP_MSB:0] > b[FLOAT_EXP_MSB:0];
        end else begin
            // both negative: smaller magnitude is the greater value
            gt = a[FLOAT_EXP_MSB:0] < b[FLOAT_EXP_MSB:0];
        end
    end

endmodule

// File: rtl/float_max_reduce.sv
// Streaming float32 max reduction over an in_last-delimited frame: reports the
// maximum, its first index, a NaN-seen flag and a frame-length overflow flag.
module float_max_reduce
    import float_max_reduce_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [31:0]            out_max,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic                   out_nan,
    output logic                   out_overflow,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam logic [INDEX_WIDTH:0] COUNT_ONE = {{INDEX_WIDTH{1'b0}}, 1'b1};
    localparam logic [INDEX_WIDTH:0] COUNT_SAT = {1'b1, {INDEX_WIDTH{1'b0}}};

    reduce_state_t          state;
    logic [INDEX_WIDTH:0]   count;
    logic                   max_is_nan;
    logic                   accept;
    logic                   sample_nan;
    logic                   sample_gt;
    logic                   replace;
    logic [INDEX_WIDTH-1:0] win_index;

    float_gt u_gt (
        .a  (in_data),
        .b  (out_max),
        .gt (sample_gt)
    );

    assign in_ready   = (state != ST_DONE);
    assign accept     = in_valid & in_ready;
    assign sample_nan = float_is_nan(in_data);
    assign replace    = !sample_nan && (max_is_nan || sample_gt);
    // once saturated, late winners report the last representable index
    assign win_index  = (count == COUNT_SAT) ? '1 : count[INDEX_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_FIRST;
            count        <= '0;
            max_is_nan   <= 1'b0;
            out_max      <= '0;
            out_index    <= '0;
            out_nan      <= 1'b0;
            out_overflow <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            case (state)
                ST_FIRST: begin
                    if (accept) begin
                        out_max      <= sample_nan ? FLOAT_NAN_CANON : in_data;
                        max_is_nan   <= sample_nan;
                        out_index    <= '0;
                        count        <= COUNT_ONE;
                        out_nan      <= sample_nan;
                        out_overflow <= 1'b0;
                        if (in_last) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        if (replace) begin
                            out_max    <= in_data;
                            max_is_nan <= 1'b0;
                            out_index  <= win_index;
                        end
                        out_nan <= out_nan | sample_nan;
                        if (count == COUNT_SAT) begin
                            out_overflow <= 1'b1;
                        end else begin
                            count <= count + COUNT_ONE;
                        end
                        if (in_last) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_FIRST;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_FIRST;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_max_reduce.sv
// Self-checking bench for float_max_reduce: directed frames plus random frames
// checked against an order-key reference model.
module tb_float_max_reduce;

    localparam int unsigned IW  = 4;
    localparam int unsigned CAP = (1 << IW) - 1;
    localparam logic [31:0] CANON = 32'h7FC0_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [31:0]   out_max;
    logic [IW-1:0] out_index;
    logic          out_nan;
    logic          out_overflow;
    logic          out_valid;
    logic          out_ready;

    int errors = 0;
    int checks = 0;

    logic [31:0] frm [0:63];
    int unsigned flen;

    always #5 clk = ~clk;

    float_max_reduce #(.INDEX_WIDTH(IW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_max      (out_max),
        .out_index    (out_index),
        .out_nan      (out_nan),
        .out_overflow (out_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // signed order key: negative values are negated magnitudes, so -0 == +0
    function automatic longint fkey(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] int_to_f(input int unsigned n);
        int unsigned e;
        logic [31:0] r;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        r = {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
        return r;
    endfunction

    function automatic logic [31:0] rand_sample();
        logic [31:0] r;
        case ($urandom_range(0, 7))
            0: r = {1'($urandom), 8'hFF, 23'($urandom) | 23'd1};
            1: r = {1'($urandom), 31'd0};
            2: r = {1'($urandom), 8'hFF, 23'd0};
            3: r = {1'($urandom), 8'h00, 23'($urandom)};
            4, 5: r = {1'($urandom), int_to_f($urandom_range(1, 6))};
            default: r = $urandom;
        endcase
        if (r[30:0] == 31'd0 && $urandom_range(0, 1) == 0) r = 32'h0000_0000;
        return r;
    endfunction

    task automatic model(output logic [31:0] emax, output logic [IW-1:0] eidx,
                         output logic enan, output logic eovf);
        longint best;
        bit found;
        found = 0;
        best  = 0;
        emax  = CANON;
        eidx  = '0;
        enan  = 1'b0;
        for (int unsigned i = 0; i < flen; i++) begin
            if (is_nan(frm[i])) begin
                enan = 1'b1;
            end else if (!found || fkey(frm[i]) > best) begin
                found = 1;
                best  = fkey(frm[i]);
                emax  = frm[i];
                eidx  = IW'((i > CAP) ? CAP : i);
            end
        end
        eovf = (flen > CAP + 1);
    endtask

    task automatic run_frame(input string tag, input bit gaps, input bit do_hs);
        logic [31:0] emax;
        logic [IW-1:0] eidx;
        logic enan, eovf;
        model(emax, eidx, enan, eovf);
        for (int unsigned i = 0; i < flen; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = frm[i];
            in_last  = (i == flen - 1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".max"}, out_max, emax);
        chk({tag, ".index"}, 32'(out_index), 32'(eidx));
        chk({tag, ".nan"}, 32'(out_nan), 32'(enan));
        chk({tag, ".ovf"}, 32'(out_overflow), 32'(eovf));
        chk({tag, ".busy"}, 32'(in_ready), 32'd0);
        if (do_hs) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk({tag, ".hs_valid"}, 32'(out_valid), 32'd0);
            chk({tag, ".hs_ready"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.max", out_max, 32'd0);
        chk("rst.index", 32'(out_index), 32'd0);
        chk("rst.nan", 32'(out_nan), 32'd0);
        chk("rst.ovf", 32'(out_overflow), 32'd0);

        frm[0] = 32'h3F80_0000; frm[1] = 32'h4040_0000; frm[2] = 32'h4000_0000; flen = 3;
        run_frame("basic", 0, 1);
        chk("basic.const_max", out_max, 32'h4040_0000);

        frm[0] = 32'h8000_0000; frm[1] = 32'h0000_0000; flen = 2;
        run_frame("zeros", 0, 1);
        chk("zeros.const_max", out_max, 32'h8000_0000);

        frm[0] = 32'h7FC0_0001; frm[1] = 32'hFF80_0000; frm[2] = 32'h0000_0001; flen = 3;
        run_frame("nan_mix", 0, 1);
        chk("nan_mix.const_index", 32'(out_index), 32'd2);

        frm[0] = 32'h7FC0_0001; frm[1] = 32'hFFFF_FFFF; frm[2] = 32'h7F80_0001; flen = 3;
        run_frame("all_nan", 0, 1);
        chk("all_nan.const_max", out_max, CANON);

        for (int unsigned i = 0; i < 20; i++) frm[i] = int_to_f(i + 1);
        flen = 20;
        run_frame("ovf20", 0, 1);
        chk("ovf20.const_max", out_max, 32'h41A0_0000);
        chk("ovf20.const_index", 32'(out_index), 32'd15);

        for (int unsigned i = 0; i < 16; i++) frm[i] = int_to_f(i + 1);
        flen = 16;
        run_frame("len16", 0, 1);

        frm[0] = 32'h4080_0000; frm[1] = 32'h4040_0000; flen = 2;
        run_frame("hold", 0, 0);
        in_valid = 1'b1; in_data = 32'h7F00_0000; in_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold.in_ready", 32'(in_ready), 32'd0);
            chk("hold.valid", 32'(out_valid), 32'd1);
            chk("hold.max", out_max, 32'h4080_0000);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("hold.rel_valid", 32'(out_valid), 32'd0);
        chk("hold.rel_ready", 32'(in_ready), 32'd1);
        frm[0] = 32'h4000_0000; frm[1] = 32'h3F80_0000; flen = 2;
        run_frame("after_hold", 0, 1);

        frm[0] = 32'h4040_0000; frm[1] = 32'h3F80_0000; frm[2] = 32'h4000_0000;
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = frm[i]; in_last = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst.valid", 32'(out_valid), 32'd0);
        chk("mrst.in_ready", 32'(in_ready), 32'd1);
        chk("mrst.max", out_max, 32'd0);
        chk("mrst.index", 32'(out_index), 32'd0);
        chk("mrst.nan", 32'(out_nan), 32'd0);
        chk("mrst.ovf", 32'(out_overflow), 32'd0);
        frm[0] = 32'h3F00_0000; flen = 1;
        run_frame("post_rst", 0, 1);

        for (int r = 0; r < 40; r++) begin
            flen = $urandom_range(1, 24);
            for (int unsigned i = 0; i < flen; i++) frm[i] = rand_sample();
            run_frame($sformatf("rand%0d", r), 1, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
